// File: rtl/ber_checker.sv
// PRBS9 bit-error-rate checker: seeds a reference from sliced samples,
// verifies alignment, then counts bits and errors while locked.
module ber_checker #(
    parameter int NBy      = 8,
    parameter int NBcnt    = 32,
    parameter int LOCK_CNT = 32,
    parameter int WIN      = 128,
    parameter int ERR_MAX  = 16
) (
    input  logic                  clkA,
    input  logic                  reset,
    input  logic                  valid,
    input  logic signed [NBy-1:0] y,
    input  logic                  clear,
    output logic                  lock,
    output logic [NBcnt-1:0]      bit_count,
    output logic [NBcnt-1:0]      err_count
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WIN + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WIN - 1);
    localparam logic [WW-1:0] ERR_LIM    = WW'((ERR_MAX < WIN) ? ERR_MAX : WIN);
    localparam bit            CAN_DROP   = (ERR_MAX < WIN);

    typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [8:0]        s_q, s_d;
    logic [3:0]        seed_cnt_q, seed_cnt_d;
    logic [MW-1:0]     match_q, match_d;
    logic [WW-1:0]     win_cnt_q, win_cnt_d;
    logic [WW-1:0]     win_err_q, win_err_d;
    logic              lock_q, lock_d;
    logic [NBcnt-1:0]  bit_q, bit_d;
    logic [NBcnt-1:0]  err_q, err_d;

    logic              d_bit;
    logic              p_bit;
    logic              miss;
    logic [WW-1:0]     win_err_inc;

    always_comb begin
        d_bit       = ~y[NBy-1] & (|y);
        p_bit       = s_q[8] ^ s_q[4];
        miss        = d_bit ^ p_bit;
        win_err_inc = win_err_q + WW'(miss);

        state_d    = state_q;
        s_d        = s_q;
        seed_cnt_d = seed_cnt_q;
        match_d    = match_q;
        win_cnt_d  = win_cnt_q;
        win_err_d  = win_err_q;
        bit_d      = bit_q;
        err_d      = err_q;

        if (valid) begin
            unique case (state_q)
                SEED: begin
                    s_d = {s_q[7:0], d_bit};
                    if (seed_cnt_q == 4'd8) begin
                        state_d    = VERIFY;
                        seed_cnt_d = '0;
                        match_d    = '0;
                    end else begin
                        seed_cnt_d = seed_cnt_q + 4'd1;
                    end
                end
                VERIFY: begin
                    s_d = {s_q[7:0], d_bit};
                    if (miss) begin
                        state_d    = SEED;
                        seed_cnt_d = '0;
                    end else if (match_q == MATCH_LAST) begin
                        state_d   = LOCKED;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        match_d = match_q + MW'(1);
                    end
                end
                LOCKED: begin
                    // Free-run the reference so a bad bit cannot corrupt later predictions
                    s_d = {s_q[7:0], p_bit};
                    if (bit_q != '1) bit_d = bit_q + NBcnt'(1);
                    if (miss && err_q != '1) err_d = err_q + NBcnt'(1);
                    if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                        if (CAN_DROP && win_err_inc > ERR_LIM) begin
                            state_d    = SEED;
                            seed_cnt_d = '0;
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + WW'(1);
                        win_err_d = win_err_inc;
                    end
                end
                default: state_d = SEED;
            endcase
        end

        if (clear) begin
            bit_d = '0;
            err_d = '0;
        end

        lock_d = (state_d == LOCKED);
    end

    always_ff @(posedge clkA or negedge reset) begin
        if (!reset) begin
            state_q    <= SEED;
            s_q        <= '0;
            seed_cnt_q <= '0;
            match_q    <= '0;
            win_cnt_q  <= '0;
            win_err_q  <= '0;
            lock_q     <= 1'b0;
            bit_q      <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            seed_cnt_q <= seed_cnt_d;
            match_q    <= match_d;
            win_cnt_q  <= win_cnt_d;
            win_err_q  <= win_err_d;
            lock_q     <= lock_d;
            bit_q      <= bit_d;
            err_q      <= err_d;
        end
    end

    assign lock      = lock_q;
    assign bit_count = bit_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_ber_checker.sv
// Directed bench for ber_checker: table of locked-mode vectors plus
// sequences for lock acquisition, window loss, relock, clear and saturation.
module tb_ber_checker;

    logic              clkA = 1'b0;
    logic              reset;
    logic              valid;
    logic signed [7:0] y;
    logic              clear;
    logic              lock;
    logic [31:0]       bit_count, err_count;
    logic              sm_lock;
    logic [3:0]        sm_bit, sm_err;

    int total = 0;
    int bad   = 0;
    logic [8:0] t;
    int lk;
    longint eb, ee;

    always #5 clkA = ~clkA;

    ber_checker dut (
        .clkA(clkA), .reset(reset), .valid(valid), .y(y), .clear(clear),
        .lock(lock), .bit_count(bit_count), .err_count(err_count)
    );

    ber_checker #(.NBcnt(4)) dut_sm (
        .clkA(clkA), .reset(reset), .valid(valid), .y(y), .clear(clear),
        .lock(sm_lock), .bit_count(sm_bit), .err_count(sm_err)
    );

    typedef struct {
        logic v;
        int   mode;
        logic clr;
        logic lk;
        int   bc;
        int   ec;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string nm, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // mode 0: clean, 1: inverted, 2: zero sample on ones
    function automatic logic signed [7:0] ymk(input int mode, input logic b);
        logic signed [7:0] r;
        case (mode)
            1:       r = b ? -8'sd32 : 8'sd32;
            2:       r = b ? 8'sd0 : -8'sd32;
            default: r = b ? 8'sd32 : -8'sd32;
        endcase
        return r;
    endfunction

    task automatic step(input logic v, input int mode, input logic clr);
        logic b;
        b = t[8] ^ t[4];
        valid = v;
        clear = clr;
        y = v ? ymk(mode, b) : ymk(1, b);
        @(posedge clkA);
        #1;
        if (v) begin
            t = {t[7:0], b};
            lk++;
        end
        valid = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        tbl[0] = '{1'b1, 0, 1'b0, 1'b1, 1, 0};
        tbl[1] = '{1'b1, 0, 1'b0, 1'b1, 2, 0};
        tbl[2] = '{1'b0, 1, 1'b0, 1'b1, 2, 0};
        tbl[3] = '{1'b1, 1, 1'b0, 1'b1, 3, 1};
        tbl[4] = '{1'b1, 0, 1'b0, 1'b1, 4, 1};
        tbl[5] = '{1'b1, 0, 1'b0, 1'b1, 5, 1};
        tbl[6] = '{1'b1, 0, 1'b1, 1'b1, 0, 0};
        tbl[7] = '{1'b1, 0, 1'b0, 1'b1, 1, 0};
        tbl[8] = '{1'b0, 0, 1'b0, 1'b1, 1, 0};
        tbl[9] = '{1'b1, 1, 1'b0, 1'b1, 2, 1};

        reset = 1'b0; valid = 1'b0; clear = 1'b0; y = '0;
        t = 9'h1FF; lk = 0;
        repeat (2) @(posedge clkA);
        #1;
        check("rst_lock", lock, 0);
        check("rst_bit", bit_count, 0);
        check("rst_err", err_count, 0);
        check("rst_sm_bit", sm_bit, 0);
        reset = 1'b1;

        repeat (40) step(1'b1, 0, 1'b0);
        check("prelock_40", lock, 0);
        step(1'b1, 0, 1'b0);
        check("lock_41", lock, 1);
        check("lock_bit0", bit_count, 0);
        check("lock_err0", err_count, 0);
        lk = 0;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].mode, tbl[i].clr);
            check($sformatf("tbl%0d_lock", i), lock, tbl[i].lk);
            check($sformatf("tbl%0d_bit", i), bit_count, tbl[i].bc);
            check($sformatf("tbl%0d_err", i), err_count, tbl[i].ec);
            check($sformatf("tbl%0d_smbit", i), sm_bit, tbl[i].bc);
            check($sformatf("tbl%0d_smerr", i), sm_err, tbl[i].ec);
        end
        eb = 2; ee = 1;

        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (t[8] ^ t[4]) found = 1'b1;
            else begin
                step(1'b1, 0, 1'b0);
                eb++;
            end
        end
        check("y0_found_one", found, 1);
        step(1'b1, 2, 1'b0);
        eb++; ee++;
        check("y0_err", err_count, ee);
        check("y0_bit", bit_count, eb);

        while (lk % 128 != 0) begin
            step(1'b1, 0, 1'b0);
            eb++;
        end
        check("align_lock", lock, 1);

        repeat (16) step(1'b1, 1, 1'b0);
        repeat (112) step(1'b1, 0, 1'b0);
        eb += 128; ee += 16;
        check("win16_lock", lock, 1);
        check("win16_err", err_count, ee);
        check("win16_bit", bit_count, eb);

        repeat (127) step(1'b1, 1, 1'b0);
        check("inv127_lock", lock, 1);
        step(1'b1, 1, 1'b0);
        eb += 128; ee += 128;
        check("inv128_lock", lock, 0);
        check("inv128_bit", bit_count, eb);
        check("inv128_err", err_count, ee);
        check("sat_sm_bit", sm_bit, 15);
        check("sat_sm_err", sm_err, 15);

        repeat (5) step(1'b1, 0, 1'b0);
        check("hold_bit", bit_count, eb);
        check("hold_err", err_count, ee);
        check("hold_lock", lock, 0);
        repeat (35) step(1'b1, 0, 1'b0);
        check("relock_40", lock, 0);
        step(1'b1, 0, 1'b0);
        check("relock_41", lock, 1);
        check("relock_bit", bit_count, eb);
        step(1'b1, 0, 1'b0);
        eb++;
        check("first_cnt", bit_count, eb);

        step(1'b1, 0, 1'b1);
        check("clr_bit", bit_count, 0);
        check("clr_err", err_count, 0);
        check("clr_lock", lock, 1);
        check("clr_sm_bit", sm_bit, 0);

        reset = 1'b0;
        #1;
        check("mid_rst_lock", lock, 0);
        check("mid_rst_bit", bit_count, 0);
        check("mid_rst_err", err_count, 0);
        @(posedge clkA);
        #1;
        reset = 1'b1;
        t = 9'h1FF;

        for (int i = 0; i < 80; i++) step(i % 2 == 0, 0, 1'b0);
        check("tog_prelock", lock, 0);
        step(1'b1, 0, 1'b0);
        check("tog_lock", lock, 1);
        step(1'b0, 0, 1'b0);
        step(1'b1, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        step(1'b1, 0, 1'b0);
        check("tog_bit", bit_count, 2);
        check("tog_err", err_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ber_checker.md
BER_CHECKER -- requirements
Module: ber_checker

Interface
REQ-001 Parameter NBy, default 8: width of equalizer output sample y (signed).
REQ-002 Parameter NBcnt, default 32: width of bit and error counters.
REQ-003 Parameter LOCK_CNT, default 32: consecutive matches needed to declare lock.
REQ-004 Parameter WIN, default 128: locked-mode monitoring window, in valid bits.
REQ-005 Parameter ERR_MAX, default 16: window error count above which lock is dropped.
REQ-006 clkA  input  1  single system clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 valid  input  1  qualifies y for the current cycle.
REQ-009 y  input  NBy  signed equalizer output sample.
REQ-010 clear  input  1  synchronous clear of statistics counters.
REQ-011 lock  output  1  high while state is LOCKED.
REQ-012 bit_count  output  NBcnt  valid bits checked while locked.
REQ-013 err_count  output  NBcnt  mismatches detected while locked.

Function
REQ-014 Slicer: d = 1 when y > 0; d = 0 when y is negative or zero.
REQ-015 Reference: 9-bit PRBS9 register s (polynomial x^9+x^5+1); predicted bit p = s[8] XOR s[4]; shift is s <= {s[7:0], in}.
REQ-016 Cycles with valid = 0 change no state, counter or output.
REQ-017 FSM states: SEED, VERIFY, LOCKED; reset state is SEED.
REQ-018 SEED: each valid bit shifts d into s and increments seed counter; on the 9th valid bit, go to VERIFY with match counter = 0.
REQ-019 VERIFY: each valid bit shifts d into s; if d == p, increment match counter; mismatch returns to SEED with seed counter = 0.
REQ-020 VERIFY: the valid bit giving LOCK_CNT consecutive matches moves the FSM to LOCKED; lock is high from the next cycle.
REQ-021 LOCKED: each valid bit shifts p (not d) into s, so the reference free-runs and errors are not multiplied.
REQ-022 LOCKED: each valid bit increments bit_count, and increments err_count when d != p.
REQ-023 LOCKED: window counter and window error counter track each WIN valid bits.
REQ-024 At window end: if window errors > ERR_MAX, go to SEED (lock low next cycle); otherwise restart the window.
REQ-025 bit_count and err_count saturate at all-ones and never wrap.
REQ-026 bit_count and err_count hold their values when lock is lost.
REQ-027 The first valid bit after lock asserts is the first bit counted.
REQ-028 clear zeroes bit_count and err_count next cycle; FSM, s and window counters are unaffected.
REQ-029 clear together with a counted valid bit: clear wins; counters become 0 and that bit is not counted.
REQ-030 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-031 reset low immediately forces: state SEED, s = 0, all internal counters 0, lock = 0, bit_count = 0, err_count = 0.
REQ-032 Reset asserted mid-operation, including in LOCKED, aborts the operation with no retained state.
REQ-033 After reset release, the first rising edge with valid = 1 is seed bit 1.

Verification
REQ-034 Error-free PRBS9 on y (+32 for 1, -32 for 0), valid always 1 -> lock rises 9+32 = 41 valid bits after reset release (+1 cycle register delay); err_count stays 0; bit_count increments once per cycle.
REQ-035 Locked, then one bit flipped -> err_count = 1 exactly; lock held; no error multiplication.
REQ-036 Locked, then inverted data for 128 bits -> window errors 128 > 16 -> lock drops after the window end; counters hold; relock occurs after 41 clean bits.
REQ-037 valid toggling 1/0 with error-free data -> lock after 41 valid bits, i.e. about 82 cycles; bit_count counts valid cycles only.
REQ-038 y = 0 on transmitted-1 bits -> sliced d = 0, counted as an error.
REQ-039 clear asserted with valid while locked -> counters read 0 next cycle, lock unchanged. With NBcnt = 4 overridden -> bit_count sticks at 15.
